lpc_cycle_queue: RTL and testbench

Controller and buffer that sits downstream of the LPC peripheral FSM's captured-cycle output (32-bit TDATA word plus READY strobe).
- Detects each new captured cycle and filters it by cycle type and an address window.
- Queues accepted cycles in a FIFO and hands them to a consumer over a valid/ready handshake.
- Typical consumers: TPM register logic, UART logger.
- Provides flush, capture enable, occupancy and drop statistics so firmware or a debug bridge can configure and monitor it.

---
 rtl/lpc_cycle_queue.sv | 142 ++++++++++++++
 tb/tb_lpc_cycle_queue.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/lpc_cycle_queue.sv
// rtl/lpc_cycle_queue.sv - filtered FIFO queue for captured LPC cycles
//
// Ports:
//   clk_i        LPC clock
//   nrst_i       asynchronous active-low reset
//   tdata_i      captured cycle word: [27:12] addr, [11:4] data, [1:0] type
//   ready_i      new-cycle strobe (level; one event per rising edge)
//   capture_en_i 1 = accept new cycles
//   flush_i      synchronous queue clear
//   win_base_i   address window base
//   win_mask_i   address compare mask (1 = bit compared)
//   clr_stat_i   clears drop_cnt_o and overflow_o
//   m_data_o     head-of-queue word (first-word-fall-through)
//   m_valid_o    queue non-empty
//   m_ready_i    consumer accepts head
//   level_o      occupancy, 0..DEPTH
//   drop_cnt_o   saturating count of cycles dropped while full
//   overflow_o   sticky drop flag
module lpc_cycle_queue #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk_i,
    input  logic          nrst_i,
    input  logic [31:0]   tdata_i,
    input  logic          ready_i,
    input  logic          capture_en_i,
    input  logic          flush_i,
    input  logic [15:0]   win_base_i,
    input  logic [15:0]   win_mask_i,
    input  logic          clr_stat_i,
    output logic [31:0]   m_data_o,
    output logic          m_valid_o,
    input  logic          m_ready_i,
    output logic [AW:0]   level_o,
    output logic [15:0]   drop_cnt_o,
    output logic          overflow_o
);

    localparam logic [AW:0] LEVEL_FULL = (AW+1)'(DEPTH);

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   level;
    logic [AW:0]   level_nxt;
    logic          ready_q;
    logic          valid_q;
    logic [15:0]   drop_cnt;
    logic          overflow;

    logic          evt;
    logic          type_ok;
    logic          addr_hit;
    logic          accept;
    logic          full;
    logic          pop;
    logic          push;
    logic          drop;

    always_comb begin
        evt      = ready_i & ~ready_q;
        // Valid types are 01 and 11, i.e. bit 0 set.
        type_ok  = tdata_i[0];
        addr_hit = ((tdata_i[27:12] ^ win_base_i) & win_mask_i) == 16'h0000;
        accept   = evt & capture_en_i & type_ok & addr_hit;
        full     = (level == LEVEL_FULL);
        pop      = valid_q & m_ready_i;
        // A pop in the same cycle frees the slot, so a full queue still takes the word.
        push     = accept & (~full | pop);
        drop     = accept & full & ~pop;

        level_nxt = level;
        if (push && !pop) begin
            level_nxt = level + (AW+1)'(1);
        end else if (pop && !push) begin
            level_nxt = level - (AW+1)'(1);
        end
    end

    // Edge detector keeps running through flush so a held strobe does not re-fire.
    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            ready_q <= 1'b0;
        end else begin
            ready_q <= ready_i;
        end
    end

    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level   <= '0;
            valid_q <= 1'b0;
        end else if (flush_i) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level   <= '0;
            valid_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            level   <= level_nxt;
            valid_q <= (level_nxt != '0);
        end
    end

    // Storage array: contents are don't-care while empty, so no reset.
    always_ff @(posedge clk_i) begin
        if (push && !flush_i) begin
            mem[wr_ptr] <= tdata_i;
        end
    end

    // Clear has priority over a same-cycle drop.
    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            drop_cnt <= 16'h0000;
            overflow <= 1'b0;
        end else if (clr_stat_i) begin
            drop_cnt <= 16'h0000;
            overflow <= 1'b0;
        end else if (drop) begin
            if (drop_cnt != 16'hFFFF) begin
                drop_cnt <= drop_cnt + 16'h0001;
            end
            overflow <= 1'b1;
        end
    end

    assign m_data_o   = mem[rd_ptr];
    assign m_valid_o  = valid_q;
    assign level_o    = level;
    assign drop_cnt_o = drop_cnt;
    assign overflow_o = overflow;

endmodule

// File: tb/tb_lpc_cycle_queue.sv
// tb/tb_lpc_cycle_queue.sv - directed self-checking bench for lpc_cycle_queue
module tb_lpc_cycle_queue;

    logic        clk_i = 1'b0;
    logic        nrst_i;
    logic [31:0] tdata_i;
    logic        ready_i;
    logic        capture_en_i;
    logic        flush_i;
    logic [15:0] win_base_i;
    logic [15:0] win_mask_i;
    logic        clr_stat_i;
    logic [31:0] m_data_o;
    logic        m_valid_o;
    logic        m_ready_i;
    logic [3:0]  level_o;
    logic [15:0] drop_cnt_o;
    logic        overflow_o;

    int vec_cnt = 0;
    int err_cnt = 0;

    lpc_cycle_queue #(.DEPTH(8), .AW(3)) dut (
        .clk_i(clk_i), .nrst_i(nrst_i), .tdata_i(tdata_i), .ready_i(ready_i),
        .capture_en_i(capture_en_i), .flush_i(flush_i), .win_base_i(win_base_i),
        .win_mask_i(win_mask_i), .clr_stat_i(clr_stat_i), .m_data_o(m_data_o),
        .m_valid_o(m_valid_o), .m_ready_i(m_ready_i), .level_o(level_o),
        .drop_cnt_o(drop_cnt_o), .overflow_o(overflow_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // One clean event: strobe high for one clock, then low for one clock.
    task automatic strobe(input logic [31:0] w);
        tdata_i = w;
        ready_i = 1'b1;
        tick();
        ready_i = 1'b0;
        tick();
    endtask

    function automatic logic [31:0] word_of(input int i);
        return 32'h0000_0001 | (32'(i & 8'hFF) << 4) | (32'(16'h0100 + i) << 12);
    endfunction

    task automatic test_reset();
        nrst_i = 1'b0; tdata_i = '0; ready_i = 0; capture_en_i = 1; flush_i = 0;
        win_base_i = '0; win_mask_i = '0; clr_stat_i = 0; m_ready_i = 0;
        tick(); tick();
        vec_cnt++; if (m_valid_o !== 1'b0) begin err_cnt++; $display("FAIL reset_valid got %0b exp 0", m_valid_o); end
        vec_cnt++; if (level_o !== 4'd0) begin err_cnt++; $display("FAIL reset_level got %0d exp 0", level_o); end
        vec_cnt++; if (drop_cnt_o !== 16'd0) begin err_cnt++; $display("FAIL reset_drop got %0d exp 0", drop_cnt_o); end
        vec_cnt++; if (overflow_o !== 1'b0) begin err_cnt++; $display("FAIL reset_ovf got %0b exp 0", overflow_o); end
        nrst_i = 1'b1;
        tick();
    endtask

    task automatic test_edge();
        tdata_i = 32'h0008_0A51;
        ready_i = 1'b1;
        tick();
        vec_cnt++; if (m_valid_o !== 1'b1) begin err_cnt++; $display("FAIL edge_valid got %0b exp 1", m_valid_o); end
        vec_cnt++; if (m_data_o !== 32'h0008_0A51) begin err_cnt++; $display("FAIL edge_data got %h exp 00080a51", m_data_o); end
        tick();
        vec_cnt++; if (level_o !== 4'd1) begin err_cnt++; $display("FAIL edge_held_level got %0d exp 1", level_o); end
        ready_i = 1'b0;
        m_ready_i = 1'b1;
        tick();
        m_ready_i = 1'b0;
        vec_cnt++; if (level_o !== 4'd0) begin err_cnt++; $display("FAIL edge_pop_level got %0d exp 0", level_o); end
        vec_cnt++; if (m_valid_o !== 1'b0) begin err_cnt++; $display("FAIL edge_pop_valid got %0b exp 0", m_valid_o); end
    endtask

    task automatic test_filter();
        win_base_i = 16'h0F00;
        win_mask_i = 16'hFF00;
        strobe(32'h00F1_2A53);
        strobe(32'h0008_0A53);
        strobe(32'h00F3_4A50);
        capture_en_i = 1'b0;
        strobe(32'h00F1_2A51);
        capture_en_i = 1'b1;
        vec_cnt++; if (level_o !== 4'd1) begin err_cnt++; $display("FAIL filter_level got %0d exp 1", level_o); end
        vec_cnt++; if (m_data_o !== 32'h00F1_2A53) begin err_cnt++; $display("FAIL filter_data got %h exp 00f12a53", m_data_o); end
        m_ready_i = 1'b1;
        tick();
        m_ready_i = 1'b0;
        win_mask_i = 16'h0000;
        vec_cnt++; if (level_o !== 4'd0) begin err_cnt++; $display("FAIL filter_drain got %0d exp 0", level_o); end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 10; i++) strobe(word_of(i));
        vec_cnt++; if (level_o !== 4'd8) begin err_cnt++; $display("FAIL ovf_level got %0d exp 8", level_o); end
        vec_cnt++; if (drop_cnt_o !== 16'd2) begin err_cnt++; $display("FAIL ovf_drop got %0d exp 2", drop_cnt_o); end
        vec_cnt++; if (overflow_o !== 1'b1) begin err_cnt++; $display("FAIL ovf_flag got %0b exp 1", overflow_o); end
        for (int i = 0; i < 8; i++) begin
            vec_cnt++; if (m_data_o !== word_of(i)) begin err_cnt++; $display("FAIL ovf_drain[%0d] got %h exp %h", i, m_data_o, word_of(i)); end
            m_ready_i = 1'b1;
            tick();
            m_ready_i = 1'b0;
        end
        vec_cnt++; if (level_o !== 4'd0) begin err_cnt++; $display("FAIL ovf_empty got %0d exp 0", level_o); end
        vec_cnt++; if (drop_cnt_o !== 16'd2) begin err_cnt++; $display("FAIL ovf_drop_kept got %0d exp 2", drop_cnt_o); end
        clr_stat_i = 1'b1;
        tick();
        clr_stat_i = 1'b0;
        vec_cnt++; if (drop_cnt_o !== 16'd0) begin err_cnt++; $display("FAIL clr_drop got %0d exp 0", drop_cnt_o); end
        vec_cnt++; if (overflow_o !== 1'b0) begin err_cnt++; $display("FAIL clr_ovf got %0b exp 0", overflow_o); end
    endtask

    task automatic test_full_pop();
        for (int i = 0; i < 8; i++) strobe(word_of(i + 32));
        tdata_i = 32'h0CAF_E771;
        ready_i = 1'b1;
        m_ready_i = 1'b1;
        tick();
        ready_i = 1'b0;
        m_ready_i = 1'b0;
        vec_cnt++; if (level_o !== 4'd8) begin err_cnt++; $display("FAIL fullpop_level got %0d exp 8", level_o); end
        vec_cnt++; if (drop_cnt_o !== 16'd0) begin err_cnt++; $display("FAIL fullpop_drop got %0d exp 0", drop_cnt_o); end
        for (int i = 1; i < 8; i++) begin
            vec_cnt++; if (m_data_o !== word_of(i + 32)) begin err_cnt++; $display("FAIL fullpop_order[%0d] got %h exp %h", i, m_data_o, word_of(i + 32)); end
            m_ready_i = 1'b1;
            tick();
            m_ready_i = 1'b0;
        end
        vec_cnt++; if (m_data_o !== 32'h0CAF_E771) begin err_cnt++; $display("FAIL fullpop_new got %h exp 0cafe771", m_data_o); end
        vec_cnt++; if (level_o !== 4'd1) begin err_cnt++; $display("FAIL fullpop_last_level got %0d exp 1", level_o); end
        m_ready_i = 1'b1;
        tick();
        m_ready_i = 1'b0;
    endtask

    task automatic test_flush();
        for (int i = 0; i < 5; i++) strobe(word_of(i + 64));
        vec_cnt++; if (level_o !== 4'd5) begin err_cnt++; $display("FAIL flush_fill got %0d exp 5", level_o); end
        tdata_i = 32'h0111_1111;
        ready_i = 1'b1;
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        vec_cnt++; if (level_o !== 4'd0) begin err_cnt++; $display("FAIL flush_level got %0d exp 0", level_o); end
        vec_cnt++; if (m_valid_o !== 1'b0) begin err_cnt++; $display("FAIL flush_valid got %0b exp 0", m_valid_o); end
        tick();
        vec_cnt++; if (level_o !== 4'd0) begin err_cnt++; $display("FAIL flush_held_strobe got %0d exp 0", level_o); end
        ready_i = 1'b0;
        tick();
        strobe(32'h0ABC_DE51);
        vec_cnt++; if (level_o !== 4'd1) begin err_cnt++; $display("FAIL flush_after_level got %0d exp 1", level_o); end
        vec_cnt++; if (m_data_o !== 32'h0ABC_DE51) begin err_cnt++; $display("FAIL flush_after_data got %h exp 0abcde51", m_data_o); end
        m_ready_i = 1'b1;
        tick();
        m_ready_i = 1'b0;
    endtask

    task automatic test_back_to_back();
        m_ready_i = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tdata_i = word_of(i + 100);
            ready_i = 1'b1;
            tick();
            vec_cnt++; if (m_data_o !== word_of(i + 100) || m_valid_o !== 1'b1) begin err_cnt++; $display("FAIL b2b_data[%0d] got %h/%0b exp %h/1", i, m_data_o, m_valid_o, word_of(i + 100)); end
            vec_cnt++; if (level_o > 4'd1) begin err_cnt++; $display("FAIL b2b_level[%0d] got %0d exp <=1", i, level_o); end
            ready_i = 1'b0;
            tick();
        end
        m_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) strobe(word_of(i + 200));
        vec_cnt++; if (level_o !== 4'd3) begin err_cnt++; $display("FAIL midrst_fill got %0d exp 3", level_o); end
        #2;
        nrst_i = 1'b0;
        #1;
        vec_cnt++; if (m_valid_o !== 1'b0) begin err_cnt++; $display("FAIL midrst_valid got %0b exp 0", m_valid_o); end
        vec_cnt++; if (level_o !== 4'd0) begin err_cnt++; $display("FAIL midrst_level got %0d exp 0", level_o); end
        tick();
        nrst_i = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_edge();
        test_filter();
        test_overflow();
        test_full_pop();
        test_flush();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
